// File: rtl/counter_seq_ctrl.sv
// Command-driven up-counter sequencer: terminal value, prescaler, start/stop/pause, one-shot or auto-reload.
// Latency: all outputs registered; a command takes effect at its accepting edge, a tick at the edge it occurs.
// Backpressure: cmd_ready drops for one cycle after every accepted command; the requester holds cmd_valid meanwhile.
module counter_seq_ctrl #(
    parameter int WIDTH = 3,
    parameter int PSC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [PSC_W-1:0] prescale,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] limit, limit_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic [PSC_W-1:0] pc, pc_nxt;
    logic             tc_nxt;
    logic             ready_nxt;
    logic             accept;
    logic             tick;

    assign accept = cmd_valid && cmd_ready;
    assign tick   = (state == RUN) && (pc == prescale);

    // Register all state and decode running/done from the next state so they are flop outputs too.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            limit     <= '1;
            pc        <= '0;
            tc        <= 1'b0;
            cmd_ready <= 1'b1;
            running   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            limit     <= limit_nxt;
            pc        <= pc_nxt;
            tc        <= tc_nxt;
            cmd_ready <= ready_nxt;
            running   <= (state_nxt == RUN);
            done      <= (state_nxt == DONE);
        end
    end

    // Next-state logic: an accepted command takes priority and swallows any tick on the same edge.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        limit_nxt = limit;
        pc_nxt    = pc;
        tc_nxt    = 1'b0;
        ready_nxt = 1'b1;
        if (accept) begin
            ready_nxt = 1'b0;
            case (cmd_op)
                OP_LOAD: begin
                    limit_nxt = cmd_data;
                    count_nxt = '0;
                    pc_nxt    = '0;
                    state_nxt = IDLE;
                end
                OP_START: begin
                    if (state == DONE) begin
                        count_nxt = '0;
                        pc_nxt    = '0;
                        state_nxt = RUN;
                    end else if (state == IDLE || state == PAUSE) begin
                        state_nxt = RUN;
                    end
                end
                OP_STOP: begin
                    if (state == RUN) begin
                        state_nxt = PAUSE;
                    end
                end
                OP_CLEAR: begin
                    count_nxt = '0;
                    pc_nxt    = '0;
                    state_nxt = IDLE;
                end
                default: ;
            endcase
        end else if (state == RUN) begin
            if (tick) begin
                pc_nxt = '0;
                if (count != limit) begin
                    count_nxt = count + 1'b1;
                end else begin
                    tc_nxt = 1'b1;
                    if (auto_reload) begin
                        count_nxt = '0;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end else begin
                pc_nxt = pc + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with hand-computed expected values.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Every command waits for cmd_ready under a cycle bound.
module tb_counter_seq_ctrl;

    localparam int WIDTH = 3;
    localparam int PSC_W = 4;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [1:0]       cmd_op = 2'b00;
    logic [WIDTH-1:0] cmd_data = '0;
    logic [PSC_W-1:0] prescale = '0;
    logic             auto_reload = 1'b0;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             running;
    logic             done;

    int n_cmp = 0;
    int n_bad = 0;

    counter_seq_ctrl #(.WIDTH(WIDTH), .PSC_W(PSC_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .count       (count),
        .tc          (tc),
        .running     (running),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one command once cmd_ready is seen, hold it across one edge, then drop it.
    task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
        int w = 0;
        while (cmd_ready !== 1'b1 && w < 20) begin
            step();
            w++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_wait_ready: cmd_ready=%b required 1", cmd_ready);
        end
        cmd_op    = op;
        cmd_data  = data;
        cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_cmp++;
        if ({count, tc, running, done, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_held: cnt/tc/run/done/rdy=%0d/%b/%b/%b/%b required 0/0/0/0/1",
                     count, tc, running, done, cmd_ready);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if ({count, tc, running, done, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL reset_released: cnt/tc/run/done/rdy=%0d/%b/%b/%b/%b required 0/0/0/0/1",
                     count, tc, running, done, cmd_ready);
        end
    endtask

    task automatic test_auto_reload();
        logic [WIDTH-1:0] ec;
        prescale    = 4'd0;
        auto_reload = 1'b1;
        send(OP_START, 3'd0);
        n_cmp++;
        if ({count, running, cmd_ready} !== {3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL start_accept: cnt/run/rdy=%0d/%b/%b required 0/1/0", count, running, cmd_ready);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            ec = WIDTH'(k % 8);
            n_cmp++;
            if ({count, tc, running} !== {ec, (k % 8 == 0), 1'b1}) begin
                n_bad++;
                $display("FAIL auto_reload k=%0d: cnt/tc/run=%0d/%b/%b required %0d/%b/1",
                         k, count, tc, running, ec, (k % 8 == 0));
            end
        end
    endtask

    task automatic test_one_shot();
        logic [WIDTH-1:0] ec;
        send(OP_LOAD, 3'd3);
        n_cmp++;
        if ({count, running, cmd_ready} !== {3'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL load_accept: cnt/run/rdy=%0d/%b/%b required 0/0/0", count, running, cmd_ready);
        end
        prescale    = 4'd2;
        auto_reload = 1'b0;
        send(OP_START, 3'd0);
        for (int k = 1; k <= 13; k++) begin
            step();
            ec = (k < 12) ? WIDTH'(k / 3) : 3'd3;
            n_cmp++;
            if ({count, tc, running, done} !== {ec, (k == 12), (k < 12), (k >= 12)}) begin
                n_bad++;
                $display("FAIL one_shot k=%0d: cnt/tc/run/done=%0d/%b/%b/%b required %0d/%b/%b/%b",
                         k, count, tc, running, done, ec, (k == 12), (k < 12), (k >= 12));
            end
        end
        send(OP_START, 3'd0);
        n_cmp++;
        if ({count, running, done} !== {3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL restart_from_done: cnt/run/done=%0d/%b/%b required 0/1/0", count, running, done);
        end
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if (count !== ((k == 3) ? 3'd1 : 3'd0)) begin
                n_bad++;
                $display("FAIL restart_count k=%0d: cnt=%0d required %0d", k, count, (k == 3) ? 1 : 0);
            end
        end
    endtask

    task automatic test_stop_resume();
        step();
        step();
        step();
        n_cmp++;
        if (count !== 3'd2) begin
            n_bad++;
            $display("FAIL pre_stop_count: cnt=%0d required 2", count);
        end
        send(OP_STOP, 3'd0);
        for (int k = 0; k <= 10; k++) begin
            if (k > 0) step();
            n_cmp++;
            if ({count, running, tc} !== {3'd2, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL paused k=%0d: cnt/run/tc=%0d/%b/%b required 2/0/0", k, count, running, tc);
            end
        end
        send(OP_START, 3'd0);
        for (int k = 1; k <= 3; k++) begin
            step();
            n_cmp++;
            if ({count, running} !== {((k == 3) ? 3'd3 : 3'd2), 1'b1}) begin
                n_bad++;
                $display("FAIL resume k=%0d: cnt/run=%0d/%b required %0d/1", k, count, running, (k == 3) ? 3 : 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] ec;
        cmd_op    = OP_LOAD;
        cmd_data  = 3'd5;
        cmd_valid = 1'b1;
        step();
        n_cmp++;
        if ({count, running, done, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_load: cnt/run/done/rdy=%0d/%b/%b/%b required 0/0/0/0", count, running, done, cmd_ready);
        end
        cmd_op      = OP_START;
        prescale    = 4'd0;
        auto_reload = 1'b1;
        step();
        n_cmp++;
        if ({running, cmd_ready} !== {1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_blocked: run/rdy=%b/%b required 0/1", running, cmd_ready);
        end
        step();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({count, running, cmd_ready} !== {3'd0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL b2b_start: cnt/run/rdy=%0d/%b/%b required 0/1/0", count, running, cmd_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            ec = (k == 6) ? 3'd0 : WIDTH'(k);
            n_cmp++;
            if ({count, tc} !== {ec, (k == 6)}) begin
                n_bad++;
                $display("FAIL b2b_limit5 k=%0d: cnt/tc=%0d/%b required %0d/%b", k, count, tc, ec, (k == 6));
            end
        end
    endtask

    task automatic test_cmd_on_tick();
        int w = 0;
        auto_reload = 1'b0;
        while (count !== 3'd5 && w < 20) begin
            step();
            w++;
        end
        n_cmp++;
        if (count !== 3'd5) begin
            n_bad++;
            $display("FAIL reach_limit: cnt=%0d required 5 within 20 cycles", count);
        end
        send(OP_CLEAR, 3'd0);
        n_cmp++;
        if ({count, tc, running, done, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clear_on_tick: cnt/tc/run/done/rdy=%0d/%b/%b/%b/%b required 0/0/0/0/0",
                     count, tc, running, done, cmd_ready);
        end
        step();
        n_cmp++;
        if ({count, tc, running, done} !== {3'd0, 1'b0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL clear_after: cnt/tc/run/done=%0d/%b/%b/%b required 0/0/0/0", count, tc, running, done);
        end
    endtask

    task automatic test_limit_zero();
        send(OP_LOAD, 3'd0);
        prescale    = 4'd0;
        auto_reload = 1'b0;
        send(OP_START, 3'd0);
        step();
        n_cmp++;
        if ({count, tc, running, done} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL limit_zero: cnt/tc/run/done=%0d/%b/%b/%b required 0/1/0/1", count, tc, running, done);
        end
    endtask

    task automatic test_async_reset();
        logic [WIDTH-1:0] ec;
        send(OP_LOAD, 3'd5);
        auto_reload = 1'b1;
        send(OP_START, 3'd0);
        step();
        step();
        n_cmp++;
        if ({count, running} !== {3'd2, 1'b1}) begin
            n_bad++;
            $display("FAIL pre_reset: cnt/run=%0d/%b required 2/1", count, running);
        end
        #3;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({count, tc, running, done, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL async_reset: cnt/tc/run/done/rdy=%0d/%b/%b/%b/%b required 0/0/0/0/1",
                     count, tc, running, done, cmd_ready);
        end
        #2;
        rst = 1'b1;
        step();
        send(OP_START, 3'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            ec = WIDTH'(k % 8);
            n_cmp++;
            if ({count, tc, running} !== {ec, (k == 8), 1'b1}) begin
                n_bad++;
                $display("FAIL post_reset_limit7 k=%0d: cnt/tc/run=%0d/%b/%b required %0d/%b/1",
                         k, count, tc, running, ec, (k == 8));
            end
        end
    endtask

    initial begin
        test_reset();
        test_auto_reload();
        test_one_shot();
        test_stop_resume();
        test_back_to_back();
        test_cmd_on_tick();
        test_limit_zero();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/counter_seq_ctrl.md
Name: counter_seq_ctrl

Overview:
- Command-driven sequencer for the team's free-running up counter datapath.
- Adds programmable terminal value, clock-enable prescaler, start/stop/pause, and one-shot or auto-reload modes.
- Exposes a valid/ready command port so a host FSM or CPU-side register block can configure and sequence the count.
- Sits between the control plane and any block that consumes `count` or the terminal-count pulse.

Parameters:
- WIDTH, 3, width of the count and limit.
- PSC_W, 4, width of the prescaler compare value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command can be accepted; a command transfers when cmd_valid && cmd_ready at a rising clk edge.
- cmd_op  input  2  command: 00 LOAD, 01 START, 10 STOP, 11 CLEAR.
- cmd_data  input  WIDTH  limit value; used by LOAD only.
- prescale  input  PSC_W  tick every prescale+1 clocks; sampled live every cycle.
- auto_reload  input  1  1 = wrap at limit and keep running; 0 = one-shot. Sampled at the tick.
- count  output  WIDTH  current count value.
- tc  output  1  one-cycle terminal-count pulse.
- running  output  1  state == RUN.
- done  output  1  state == DONE.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; count=0; limit register = all ones; prescaler pc=0.
  - tc=0, running=0, done=0, cmd_ready=1.
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Prescaler (RUN only):
  - Each clk: if pc==prescale then pc<=0 and a tick occurs; else pc<=pc+1.
  - prescale=0 gives a tick every clock.
  - pc holds in all other states.
- Tick in RUN:
  - count != limit: count<=count+1.
  - count == limit: tc<=1 for one cycle, then:
    - auto_reload=1: count<=0, stay RUN.
    - auto_reload=0: count held at limit, state<=DONE.
- Latency: START accepted at edge N sets running=1 after edge N. With prescale=0 the first increment is visible after edge N+1.
- Commands, applied at the accepting edge:
  - LOAD: limit<=cmd_data; count<=0; pc<=0; state<=IDLE from any state.
  - START:
    - IDLE or PAUSE -> RUN; count and pc are kept, so a resume continues from the held value.
    - DONE -> RUN with count<=0, pc<=0.
    - RUN: no effect.
  - STOP: RUN -> PAUSE with count and pc held; no effect in other states.
  - CLEAR: count<=0; pc<=0; state<=IDLE; limit kept.
- Handshake:
  - cmd_ready drops to 0 for exactly one cycle after each accepted command, then returns to 1. Maximum rate is one command per 2 clocks.
  - cmd_valid while cmd_ready=0 is not accepted; the requester holds the command.
- Simultaneous events:
  - A command accepted on the same edge as a tick wins.
  - That tick is discarded: no increment, no tc, no DONE transition.
- limit=0 in RUN: tc fires on every tick and count stays 0; with auto_reload=0 it reaches DONE on the first tick.
- Wrap-around: count never exceeds limit. With limit = all ones and auto_reload=1, count rolls to 0 via reload, not via overflow.
- Reset mid-operation: returns immediately to the reset values, independent of clk. Any in-flight command is lost and limit returns to all ones.

Test Plan:
1. Reset, then START with prescale=0, auto_reload=1, default limit 7 -> count steps 1..7 on consecutive clocks. tc=1 in the cycle after count=7 is reached, then count=0 and counting continues. tc period is 8 clocks.
2. LOAD 3, START, prescale=2, auto_reload=0 -> count increments every 3 clocks: 1, 2, 3. tc pulses once, done=1, running=0, count held at 3. A later START restarts from 0.
3. While RUN at count=2, STOP -> count holds at 2 for 10 clocks with running=0. START resumes: next tick gives count=3.
4. Back-to-back cmd_valid for LOAD then START -> cmd_ready=0 the cycle after LOAD. START is accepted one cycle later, with no command lost or duplicated.
5. Command (CLEAR) accepted on the exact edge of a tick at count=limit -> no tc pulse, count=0, state IDLE.
6. Assert rst=0 asynchronously mid-RUN between clock edges -> count=0, tc=0, running=0, done=0 and cmd_ready=1 immediately. A post-reset START counts toward limit 7.
